// File: rtl/serial_bit_feeder.sv
// Word-to-bit serialiser feeding the "1001" detector input.
// Ports: din/din_valid/din_ready in, bit_out/bit_valid/level out.
module serial_bit_feeder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         din,
    input  logic                     din_valid,
    output logic                     din_ready,
    output logic                     bit_out,
    output logic                     bit_valid,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nx;
    logic [CW-1:0]    bitcnt;
    logic [CW-1:0]    bitcnt_nx;
    logic             push;
    logic             pop;
    logic             has_word;

    // Full check uses registered level only, so a pop on the
    // same edge never frees room for a push.
    assign din_ready = (level != (AW+1)'(DEPTH));
    assign push      = din_valid && din_ready;
    // Registered level excludes a word pushed on this edge.
    assign has_word  = (level != '0);

    assign bit_valid = (state == SHIFT);
    assign bit_out   = (state == SHIFT) ? shreg[WIDTH-1] : 1'b0;

    always_comb begin
        state_nx  = state;
        shreg_nx  = shreg;
        bitcnt_nx = bitcnt;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (has_word) begin
                    pop       = 1'b1;
                    shreg_nx  = mem[rd_ptr];
                    bitcnt_nx = CW'(WIDTH - 1);
                    state_nx  = SHIFT;
                end
            end
            SHIFT: begin
                if (bitcnt != '0) begin
                    shreg_nx  = {shreg[WIDTH-2:0], 1'b0};
                    bitcnt_nx = bitcnt - 1'b1;
                end else if (has_word) begin
                    // Back-to-back reload keeps the line busy.
                    pop       = 1'b1;
                    shreg_nx  = mem[rd_ptr];
                    bitcnt_nx = CW'(WIDTH - 1);
                end else begin
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            state  <= state_nx;
            shreg  <= shreg_nx;
            bitcnt <= bitcnt_nx;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset; level marks which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Randomised and directed checks of serial_bit_feeder
// against a queue-based reference of words and pending bits.
module tb_serial_bit_feeder;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         bit_out;
    logic         bit_valid;
    logic [2:0]   level;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q[$];
    bit           cur[$];

    serial_bit_feeder #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic chk_all();
        chk("bit_valid", bit_valid, cur.size() > 0);
        chk("bit_out", bit_out, cur.size() > 0 ? cur[0] : 1'b0);
        chk("level", level, q.size());
        chk("din_ready", din_ready, q.size() != D);
    endtask

    // Reference: a word leaves the queue when the line is idle or
    // showing its final bit; otherwise one bit is consumed.
    task automatic model_edge(input logic v, input logic [W-1:0] d);
        logic         acc;
        logic [W-1:0] w;
        acc = v && (q.size() != D);
        if (cur.size() <= 1) begin
            cur.delete();
            if (q.size() > 0) begin
                w = q.pop_front();
                for (int i = W - 1; i >= 0; i--) cur.push_back(w[i]);
            end
        end else begin
            void'(cur.pop_front());
        end
        if (acc) q.push_back(d);
    endtask

    task automatic step(input logic v, input logic [W-1:0] d);
        din_valid = v;
        din       = d;
        @(posedge clk);
        model_edge(v, d);
        #1;
        chk_all();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        q.delete();
        cur.delete();
        #1;
        chk_all();
        @(posedge clk);
        #1;
        chk_all();
        rst_n = 1'b1;
    endtask

    logic [W-1:0]  w90;
    logic [15:0]   w16;
    logic [W-1:0]  fw [6];
    int            idx;
    int            guard;
    logic          rdy;

    initial begin
        rst_n     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", din_ready, 1);
        chk("rst_bit", bit_out, 0);
        chk("rst_valid", bit_valid, 0);
        chk("rst_level", level, 0);
        rst_n = 1'b1;

        // Single word
        w90 = 8'h90;
        step(1'b1, w90);
        chk("single_pre", bit_valid, 0);
        for (int i = W - 1; i >= 0; i--) begin
            step(1'b0, '0);
            chk("single_bit", bit_out, w90[i]);
            chk("single_vld", bit_valid, 1);
        end
        step(1'b0, '0);
        chk("single_end", bit_valid, 0);
        repeat (2) step(1'b0, '0);

        // Back-to-back
        w16 = 16'h9909;
        step(1'b1, 8'h99);
        step(1'b1, 8'h09);
        chk("b2b_bit", bit_out, w16[15]);
        for (int i = 14; i >= 0; i--) begin
            step(1'b0, '0);
            chk("b2b_bit", bit_out, w16[i]);
            chk("b2b_vld", bit_valid, 1);
        end
        step(1'b0, '0);
        chk("b2b_end", bit_valid, 0);

        // Fill
        fw = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        idx   = 0;
        guard = 0;
        while (idx < 6 && guard < 30) begin
            rdy = (q.size() != D);
            step(1'b1, fw[idx]);
            if (rdy) idx++;
            if (idx == 5 && guard == 4) begin
                chk("fill_level", level, 4);
                chk("fill_ready", din_ready, 0);
            end
            guard++;
        end
        chk("fill_done", idx, 6);
        chk("fill_cycles", guard, 11);

        // Push into full FIFO is ignored
        repeat (3) begin
            step(1'b1, 8'hFF);
            chk("full_level", level, 4);
        end
        repeat (40) step(1'b0, '0);

        // Reset during third bit of F0
        step(1'b1, 8'hF0);
        step(1'b1, 8'hA5);
        step(1'b1, 8'h3C);
        step(1'b0, '0);
        chk("mid_lvl_pre", level, 2);
        do_reset();
        chk("mid_level", level, 0);
        chk("mid_valid", bit_valid, 0);
        repeat (12) begin
            step(1'b0, '0);
            chk("mid_idle", bit_valid, 0);
        end

        // Randomised traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else if (n % 300 < 150) begin
                step($urandom_range(0, 3) == 0, W'($urandom));
            end else begin
                step($urandom_range(0, 3) != 0, W'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
